// File: rtl/lpddr_init.sv
// -----------------------------------------------------------------------------
// lpddr_init
//
// Power-up initialisation sequencer for an LPDDR device behind a PHY.
// After reset it waits for supply/clock stabilisation, then issues the JEDEC
// style init commands to the PHY one at a time:
//   PRECHARGE_ALL, REFRESH, REFRESH, LOAD_MODE, LOAD_EMODE
// Each command is followed by a mandatory idle gap. After that it runs DQS
// calibration, retrying a bounded number of times. It ends in one of two
// terminal states, reported by the sticky flags lpddr_calib_done and
// lpddr_calib_fail.
//
// Ports
//   sysclk            in   sole clock, rising edge
//   reset             in   asynchronous, active-high
//   init_cmd[2:0]     out  0 NOP, 1 PRECHARGE_ALL, 2 REFRESH, 3 LOAD_MODE,
//                          4 LOAD_EMODE
//   init_mode[13:0]   out  mode-register value with LOAD_MODE/LOAD_EMODE,
//                          otherwise 0
//   init_cmd_valid    out  command request to the PHY
//   init_cmd_ack      in   PHY accepted the command
//   cal_req           out  one-cycle pulse, starts one calibration attempt
//   cal_done          in   one-cycle pulse, calibration attempt finished
//   cal_pass          in   attempt result, qualified by cal_done
//   lpddr_calib_done  out  initialised and calibrated (sticky)
//   lpddr_calib_fail  out  every calibration attempt failed (sticky)
//   dbg_state[3:0]    out  current FSM state encoding, for observation only
//
// Command handshake (init_cmd_valid / init_cmd_ack):
//   A command transfers on a rising edge where both valid and ack are high.
//   While valid is high and no ack has been sampled, init_cmd and init_mode
//   are held stable. Valid drops on the cycle after the transfer edge. An ack
//   sampled while valid is low has no effect. Ack may arrive on the first
//   valid cycle.
// -----------------------------------------------------------------------------
module lpddr_init #(
  parameter logic [15:0] PWRUP_CYCLES = 16'd20000,
  parameter logic [3:0]  TRP_CYCLES   = 4'd3,
  parameter logic [4:0]  TRFC_CYCLES  = 5'd11,
  parameter logic [11:0] CAL_TIMEOUT  = 12'd4095,
  parameter logic [1:0]  CAL_RETRIES  = 2'd3,
  parameter logic [13:0] MODE_REG     = 14'h0032,
  parameter logic [13:0] EMODE_REG    = 14'h0000
) (
  input  logic        sysclk,
  input  logic        reset,
  output logic [2:0]  init_cmd,
  output logic [13:0] init_mode,
  output logic        init_cmd_valid,
  input  logic        init_cmd_ack,
  output logic        cal_req,
  input  logic        cal_done,
  input  logic        cal_pass,
  output logic        lpddr_calib_done,
  output logic        lpddr_calib_fail,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_PWRUP   = 4'd0,
    S_PRE     = 4'd1,
    S_REF1    = 4'd2,
    S_REF2    = 4'd3,
    S_LMR     = 4'd4,
    S_EMR     = 4'd5,
    S_CAL     = 4'd6,
    S_CALWAIT = 4'd7,
    S_DONE    = 4'd8,
    S_FAIL    = 4'd9
  } state_e;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_PRE   = 3'd1;
  localparam logic [2:0] CMD_REF   = 3'd2;
  localparam logic [2:0] CMD_LMR   = 3'd3;
  localparam logic [2:0] CMD_EMR   = 3'd4;

  // Terminal counts of the shared 16-bit counter in each use.
  localparam logic [15:0] PWRUP_LAST = PWRUP_CYCLES - 16'd1;
  localparam logic [15:0] TRP_LAST   = {12'd0, TRP_CYCLES} - 16'd1;
  localparam logic [15:0] TRFC_LAST  = {11'd0, TRFC_CYCLES} - 16'd1;
  localparam logic [15:0] CAL_TO     = {4'd0, CAL_TIMEOUT};

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic        phase_q;     // 0: issuing the command, 1: idle gap after it
  logic [15:0] cnt_q;       // power-up, gap or calibration-timeout count
  logic [1:0]  attempt_q;   // failed calibration attempts so far
  logic [2:0]  cmd_q;
  logic [13:0] mode_q;
  logic        valid_q;
  logic        cal_req_q;
  logic        done_q;
  logic        fail_q;

  // ---------------------------------------------------------------------------
  // Command encoding for each command state
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] cmd_code(input state_e s);
    logic [2:0] c;
    c = CMD_NOP;
    case (s)
      S_PRE:         c = CMD_PRE;
      S_REF1, S_REF2: c = CMD_REF;
      S_LMR:         c = CMD_LMR;
      S_EMR:         c = CMD_EMR;
      default:       c = CMD_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [13:0] mode_val(input state_e s);
    logic [13:0] m;
    m = 14'd0;
    case (s)
      S_LMR:   m = MODE_REG;
      S_EMR:   m = EMODE_REG;
      default: m = 14'd0;
    endcase
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state helpers
  // ---------------------------------------------------------------------------
  state_e      next_cmd_st;   // state entered when the current gap ends
  logic [15:0] gap_last;      // last count value of the current gap
  logic [15:0] cnt_inc;       // saturating increment of cnt_q
  logic [1:0]  attempt_inc;   // saturating increment of attempt_q
  logic        retry_ok;      // another calibration attempt is allowed

  always_comb begin
    next_cmd_st = S_PWRUP;
    case (state_q)
      S_PRE:   next_cmd_st = S_REF1;
      S_REF1:  next_cmd_st = S_REF2;
      S_REF2:  next_cmd_st = S_LMR;
      S_LMR:   next_cmd_st = S_EMR;
      S_EMR:   next_cmd_st = S_CAL;
      default: next_cmd_st = S_PWRUP;
    endcase
  end

  always_comb begin
    gap_last = TRP_LAST;
    if (state_q == S_REF1 || state_q == S_REF2) begin
      gap_last = TRFC_LAST;
    end
  end

  always_comb begin
    cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    attempt_inc = (attempt_q == 2'd3) ? attempt_q : attempt_q + 2'd1;
    // Compared one bit wider so the increment itself cannot wrap.
    retry_ok    = ({1'b0, attempt_q} + 3'd1) < {1'b0, CAL_RETRIES};
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_PWRUP;
      phase_q   <= 1'b0;
      cnt_q     <= 16'd0;
      attempt_q <= 2'd0;
      cmd_q     <= CMD_NOP;
      mode_q    <= 14'd0;
      valid_q   <= 1'b0;
      cal_req_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      case (state_q)
        S_PWRUP: begin
          if (cnt_q >= PWRUP_LAST) begin
            // Enter S_PRE with the request already presented.
            state_q <= S_PRE;
            phase_q <= 1'b0;
            cnt_q   <= 16'd0;
            valid_q <= 1'b1;
            cmd_q   <= cmd_code(S_PRE);
            mode_q  <= mode_val(S_PRE);
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_PRE, S_REF1, S_REF2, S_LMR, S_EMR: begin
          if (!phase_q) begin
            if (valid_q && init_cmd_ack) begin
              valid_q <= 1'b0;
              cmd_q   <= CMD_NOP;
              mode_q  <= 14'd0;
              phase_q <= 1'b1;
              cnt_q   <= 16'd0;
            end
          end else if (cnt_q >= gap_last) begin
            // Gap over: the following state starts its work in the very
            // next cycle, so its request is registered on this edge.
            state_q <= next_cmd_st;
            phase_q <= 1'b0;
            cnt_q   <= 16'd0;
            if (next_cmd_st == S_CAL) begin
              cal_req_q <= 1'b1;
            end else begin
              valid_q <= 1'b1;
              cmd_q   <= cmd_code(next_cmd_st);
              mode_q  <= mode_val(next_cmd_st);
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_CAL: begin
          cal_req_q <= 1'b0;
          state_q   <= S_CALWAIT;
          cnt_q     <= 16'd0;
        end

        S_CALWAIT: begin
          // A result wins over a timeout landing on the same edge.
          if (cal_done && cal_pass) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (cal_done || cnt_q >= CAL_TO) begin
            attempt_q <= attempt_inc;
            cnt_q     <= 16'd0;
            if (retry_ok) begin
              state_q   <= S_CAL;
              cal_req_q <= 1'b1;
            end else begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_DONE, S_FAIL: begin
          // Terminal: only reset leaves.
          state_q <= state_q;
        end

        default: begin
          state_q <= S_PWRUP;
          cnt_q   <= 16'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign init_cmd         = cmd_q;
  assign init_mode        = mode_q;
  assign init_cmd_valid   = valid_q;
  assign cal_req          = cal_req_q;
  assign lpddr_calib_done = done_q;
  assign lpddr_calib_fail = fail_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_lpddr_init.sv
// -----------------------------------------------------------------------------
// tb_lpddr_init
//
// Bench for lpddr_init with short timing parameters. A small PHY/calibration
// model answers the DUT; the expected command stream, idle gaps, calibration
// spacing and outcome are queued at the start of each run and compared as the
// DUT produces them.
// -----------------------------------------------------------------------------
module tb_lpddr_init;

  localparam int PWRUP   = 4;
  localparam int TRP     = 2;
  localparam int TRFC    = 3;
  localparam int CALTO   = 8;
  localparam int RETRIES = 3;
  localparam int BUDGET  = 300;

  // Calibration responses per attempt
  localparam int R_PASS    = 0;  // pass, 2nd cycle after cal_req
  localparam int R_FAIL    = 1;  // fail, 2nd cycle after cal_req
  localparam int R_NONE    = 2;  // no result (stray pass while in S_CAL)
  localparam int R_PASS_TO = 3;  // pass on the timeout cycle

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic [2:0]  init_cmd;
  logic [13:0] init_mode;
  logic        init_cmd_valid;
  logic        init_cmd_ack = 1'b0;
  logic        cal_req;
  logic        cal_done = 1'b0;
  logic        cal_pass = 1'b0;
  logic        lpddr_calib_done;
  logic        lpddr_calib_fail;
  logic [3:0]  dbg_state;

  always #5 sysclk = ~sysclk;

  lpddr_init #(
    .PWRUP_CYCLES (16'd4),
    .TRP_CYCLES   (4'd2),
    .TRFC_CYCLES  (5'd3),
    .CAL_TIMEOUT  (12'd8),
    .CAL_RETRIES  (2'd3),
    .MODE_REG     (14'h0032),
    .EMODE_REG    (14'h0000)
  ) dut (
    .sysclk           (sysclk),
    .reset            (reset),
    .init_cmd         (init_cmd),
    .init_mode        (init_mode),
    .init_cmd_valid   (init_cmd_valid),
    .init_cmd_ack     (init_cmd_ack),
    .cal_req          (cal_req),
    .cal_done         (cal_done),
    .cal_pass         (cal_pass),
    .lpddr_calib_done (lpddr_calib_done),
    .lpddr_calib_fail (lpddr_calib_fail),
    .dbg_state        (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_q[$];    // {cmd, mode} in acceptance order
  logic [7:0]  gap_q[$];    // idle gap after each command
  logic [7:0]  space_q[$];  // cycles between consecutive cal_req pulses

  int ack_wait [5];         // valid cycles before ack, per command
  int resp [4];
  int n_resp;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_acks(input int a0, input int a1, input int a2,
                          input int a3, input int a4);
    ack_wait[0] = a0; ack_wait[1] = a1; ack_wait[2] = a2;
    ack_wait[3] = a3; ack_wait[4] = a4;
  endtask

  task automatic set_resp(input int n, input int r0, input int r1, input int r2);
    n_resp = n; resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = R_NONE;
  endtask

  // ---------------------------------------------------------------------------
  // Driver + monitor: one full init run from reset. abort_idx selects the
  // command index at which reset is thrown in while valid is high.
  // ---------------------------------------------------------------------------
  task automatic run_seq(input int abort_idx);
    int cyc, vcnt, gap_cnt, cmd_idx, nreq, last_req, term_cyc, cur, since, r;
    int exp_nreq, exp_lat;
    bit in_gap, ack_pending, aborted, terminal, seen_valid, prev_cal_req;
    bit exp_done, exp_fail;
    logic [2:0]  hold_cmd;
    logic [13:0] hold_mode;
    logic [16:0] e;
    logic [7:0]  g;

    // Expected behaviour of this run
    exp_q.delete(); gap_q.delete(); space_q.delete();
    exp_q.push_back({3'd1, 14'h0000});
    exp_q.push_back({3'd2, 14'h0000});
    exp_q.push_back({3'd2, 14'h0000});
    exp_q.push_back({3'd3, 14'h0032});
    exp_q.push_back({3'd4, 14'h0000});
    gap_q.push_back(8'(TRP));
    gap_q.push_back(8'(TRFC));
    gap_q.push_back(8'(TRFC));
    gap_q.push_back(8'(TRP));
    gap_q.push_back(8'(TRP));
    exp_done = 0; exp_fail = 0; exp_nreq = 0; exp_lat = 0;
    for (int a = 0; a < n_resp; a++) begin
      exp_nreq = a + 1;
      if (resp[a] == R_PASS)    begin exp_done = 1; exp_lat = 3;         break; end
      if (resp[a] == R_PASS_TO) begin exp_done = 1; exp_lat = CALTO + 2; break; end
      if (a + 1 >= RETRIES) begin
        exp_fail = 1;
        exp_lat  = (resp[a] == R_FAIL) ? 3 : CALTO + 2;
        break;
      end
      space_q.push_back(8'((resp[a] == R_FAIL) ? 3 : CALTO + 2));
    end

    // Reset phase
    reset = 1'b1; init_cmd_ack = 1'b0; cal_done = 1'b0; cal_pass = 1'b0;
    repeat (2) @(negedge sysclk);
    check_eq("reset_outputs",
             32'({init_cmd, init_mode, init_cmd_valid, cal_req,
                  lpddr_calib_done, lpddr_calib_fail}), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    cyc = 0; vcnt = 0; gap_cnt = 0; cmd_idx = 0; nreq = 0; last_req = 0;
    term_cyc = 0; cur = 0; in_gap = 0; ack_pending = 0; aborted = 0;
    terminal = 0; seen_valid = 0; prev_cal_req = 0;
    hold_cmd = 3'd0; hold_mode = 14'd0;

    while (!aborted && cyc < BUDGET && !(terminal && cyc - term_cyc >= 6)) begin
      @(negedge sysclk);
      cyc++;

      // Invariants
      check_eq("done_fail_excl", 32'(lpddr_calib_done & lpddr_calib_fail), 32'd0);
      check_eq("mode_zero", 32'((init_cmd == 3'd3 || init_cmd == 3'd4) ? 14'd0 : init_mode), 32'd0);
      check_eq("nop_idle", 32'(init_cmd_valid ? 3'd0 : init_cmd), 32'd0);
      check_eq("cal_req_1cyc", 32'(cal_req & prev_cal_req), 32'd0);
      prev_cal_req = cal_req;

      if (init_cmd_valid && !seen_valid) begin
        seen_valid = 1;
        check_eq("pwrup_len", 32'(cyc), 32'(PWRUP));
      end

      // Cycle after a transfer: valid must already be down
      if (ack_pending) begin
        check_eq("valid_drop", 32'({init_cmd_valid, init_cmd}), 32'd0);
        ack_pending = 0; in_gap = 1; gap_cnt = 0;
      end
      if (in_gap) begin
        if (init_cmd_valid || cal_req) begin
          in_gap = 0;
          if (gap_q.size() == 0) check_eq("gap_extra", 32'd0, 32'd1);
          else begin g = gap_q.pop_front(); check_eq("gap_len", 32'(gap_cnt), 32'(g)); end
        end else begin
          gap_cnt++;
        end
      end

      // PHY model
      init_cmd_ack = 1'b0;
      if (init_cmd_valid) begin
        if (vcnt == 0) begin
          hold_cmd = init_cmd; hold_mode = init_mode;
        end else begin
          check_eq("cmd_stable", 32'({init_cmd, init_mode}), 32'({hold_cmd, hold_mode}));
        end
        vcnt++;
        if (cmd_idx >= 5) begin
          if (vcnt == 1) check_eq("cmd_extra", 32'(init_cmd), 32'd0);
        end else if (vcnt == ack_wait[cmd_idx]) begin
          init_cmd_ack = 1'b1; ack_pending = 1;
          if (exp_q.size() == 0) check_eq("cmd_missing_exp", 32'd0, 32'd1);
          else begin e = exp_q.pop_front(); check_eq("cmd_order", 32'({init_cmd, init_mode}), 32'(e)); end
          cmd_idx++; vcnt = 0;
        end else if (cmd_idx == abort_idx && vcnt == 3) begin
          aborted = 1;
        end
      end else begin
        if (vcnt != 0 && cmd_idx < 5) check_eq("valid_held", 32'(vcnt), 32'(ack_wait[cmd_idx]));
        vcnt = 0;
        init_cmd_ack = 1'($urandom_range(0, 1));  // must be ignored
      end

      // Terminal detection and post-terminal quiet checks
      if (!terminal && (lpddr_calib_done || lpddr_calib_fail)) begin
        terminal = 1; term_cyc = cyc;
        check_eq("end_latency", 32'(cyc - last_req), 32'(exp_lat));
      end

      // Calibration model
      cal_done = 1'b0; cal_pass = 1'b0;
      if (cal_req) begin
        if (nreq > 0) begin
          if (space_q.size() == 0) check_eq("cal_req_extra", 32'd0, 32'd1);
          else begin g = space_q.pop_front(); check_eq("cal_spacing", 32'(cyc - last_req), 32'(g)); end
        end
        cur = nreq; nreq++; last_req = cyc;
      end
      if (terminal) begin
        check_eq("terminal_outputs",
                 32'({init_cmd_valid, cal_req, init_cmd, lpddr_calib_done, lpddr_calib_fail}),
                 32'({1'b0, 1'b0, 3'd0, exp_done, exp_fail}));
        cal_done = 1'($urandom_range(0, 1));      // stray results, must be ignored
      end else if (nreq > 0) begin
        since = cyc - last_req;
        r = (cur < n_resp) ? resp[cur] : R_NONE;
        case (r)
          R_PASS:    if (since == 2) begin cal_done = 1'b1; cal_pass = 1'b1; end
          R_FAIL:    if (since == 2) cal_done = 1'b1;
          R_NONE:    if (since == 0) begin cal_done = 1'b1; cal_pass = 1'b1; end
          R_PASS_TO: if (since == CALTO + 1) begin cal_done = 1'b1; cal_pass = 1'b1; end
          default:   cal_done = 1'b0;
        endcase
      end

      // Asynchronous reset thrown in mid-command, before the next edge
      if (aborted) begin
        check_eq("abort_valid_high", 32'(init_cmd_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset_outputs",
                 32'({init_cmd, init_mode, init_cmd_valid, cal_req,
                      lpddr_calib_done, lpddr_calib_fail}), 32'd0);
        check_eq("async_reset_state", 32'(dbg_state), 32'd0);
        init_cmd_ack = 1'b0; cal_done = 1'b0; cal_pass = 1'b0;
      end
    end

    if (!aborted) begin
      check_eq("reached_end", 32'(terminal), 32'd1);
      check_eq("cal_req_count", 32'(nreq), 32'(exp_nreq));
      check_eq("cmds_left", 32'(exp_q.size()), 32'd0);
      check_eq("gaps_left", 32'(gap_q.size()), 32'd0);
      check_eq("spacing_left", 32'(space_q.size()), 32'd0);
      check_eq("final_flags", 32'({lpddr_calib_done, lpddr_calib_fail}),
               32'({exp_done, exp_fail}));
    end
    init_cmd_ack = 1'b0; cal_done = 1'b0; cal_pass = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    // Nominal: zero-wait ack, pass on first attempt
    set_acks(1, 1, 1, 1, 1);
    set_resp(1, R_PASS, R_NONE, R_NONE);
    run_seq(99);

    // Slow PHY on PRECHARGE_ALL
    set_acks(5, 1, 1, 1, 1);
    set_resp(1, R_PASS, R_NONE, R_NONE);
    run_seq(99);

    // Retry: fail then pass, random ack latencies
    set_acks($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
             $urandom_range(1, 3), $urandom_range(1, 3));
    set_resp(2, R_FAIL, R_PASS, R_NONE);
    run_seq(99);

    // Timeout on every attempt
    set_acks(1, 2, 1, 3, 1);
    set_resp(3, R_NONE, R_NONE, R_NONE);
    run_seq(99);

    // Pass arriving on the timeout cycle
    set_acks(1, 1, 1, 1, 1);
    set_resp(1, R_PASS_TO, R_NONE, R_NONE);
    run_seq(99);

    // Reset during the second REFRESH while valid is high
    set_acks(1, 1, 100, 1, 1);
    set_resp(1, R_PASS, R_NONE, R_NONE);
    run_seq(2);

    // Restart after that reset; all attempts fail explicitly
    set_acks(2, 1, 1, 1, 4);
    set_resp(3, R_FAIL, R_FAIL, R_FAIL);
    run_seq(99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpddr_init.md
LPDDR_INIT -- requirements
Module: lpddr_init

Interface
REQ-001 Parameter PWRUP_CYCLES, default 16'd20000, power-up stabilisation wait in sysclk cycles (must be >=1).
REQ-002 Parameter TRP_CYCLES, default 4'd3, idle gap after PRECHARGE_ALL, LOAD_MODE and LOAD_EMODE (must be >=1).
REQ-003 Parameter TRFC_CYCLES, default 5'd11, idle gap after each REFRESH (must be >=1).
REQ-004 Parameter CAL_TIMEOUT, default 12'd4095, maximum wait for a calibration result, in cycles.
REQ-005 Parameter CAL_RETRIES, default 2'd3, number of calibration attempts before failure (must be >=1).
REQ-006 Parameter MODE_REG, default 14'h0032, value driven on init_mode during LOAD_MODE.
REQ-007 Parameter EMODE_REG, default 14'h0000, value driven on init_mode during LOAD_EMODE.
REQ-008 sysclk  in  1  sole clock; all state changes on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high; driven by the lpddr_reset output of the reset sequencer.
REQ-010 init_cmd  out  3  command code: 0 NOP, 1 PRECHARGE_ALL, 2 REFRESH, 3 LOAD_MODE, 4 LOAD_EMODE.
REQ-011 init_mode  out  14  mode-register value; must be valid whenever init_cmd is 3 or 4; 0 otherwise.
REQ-012 init_cmd_valid  out  1  command request to the PHY.
REQ-013 init_cmd_ack  in  1  PHY accepted the command.
REQ-014 cal_req  out  1  one-cycle pulse that starts one DQS calibration attempt.
REQ-015 cal_done  in  1  one-cycle pulse: calibration attempt finished.
REQ-016 cal_pass  in  1  result of the attempt; qualified by cal_done.
REQ-017 lpddr_calib_done  out  1  memory is initialised and calibrated; sticky until reset.
REQ-018 lpddr_calib_fail  out  1  all calibration attempts failed; sticky until reset.

Function
REQ-019 States, in order: S_PWRUP, S_PRE, S_REF1, S_REF2, S_LMR, S_EMR, S_CAL, S_CALWAIT, S_DONE, S_FAIL.
REQ-020 S_PWRUP counts from 0. When the count reaches PWRUP_CYCLES-1, the block moves to S_PRE on the next edge.
REQ-021 Each command state (S_PRE, S_REF1, S_REF2, S_LMR, S_EMR) has two phases:
- Issue: assert init_cmd_valid with init_cmd and init_mode held stable until init_cmd_ack is sampled high; valid drops on the cycle after that edge.
- Gap: hold NOP and valid low for exactly the gap count. The gap is TRFC_CYCLES after REFRESH and TRP_CYCLES after the other commands.
- Advance: move to the next state on the edge that ends the gap.
REQ-022 init_cmd_ack while init_cmd_valid is low is ignored. An ack on the first valid cycle is legal (zero-wait acceptance).
REQ-023 S_CAL drives cal_req high for exactly one cycle, then moves to S_CALWAIT with its timeout counter at 0.
REQ-024 In S_CALWAIT:
- cal_done with cal_pass=1: go to S_DONE.
- cal_done with cal_pass=0: count as a failed attempt.
- Timeout counter reaching CAL_TIMEOUT with no cal_done: count as a failed attempt.
- cal_done and timeout on the same cycle: cal_done takes priority.
REQ-025 After a failed attempt, the 2-bit attempt counter increments. If it is below CAL_RETRIES, return to S_CAL (new cal_req). Otherwise go to S_FAIL.
REQ-026 cal_done pulses outside S_CALWAIT are ignored.
REQ-027 In S_DONE: lpddr_calib_done=1, NOP, no further requests.
REQ-028 In S_FAIL: lpddr_calib_fail=1, NOP, no further requests.
REQ-029 S_DONE and S_FAIL are terminal; only reset leaves them.
REQ-030 lpddr_calib_done and lpddr_calib_fail are never high at the same time.
REQ-031 All counters saturate at their terminal values and never wrap.

Reset
REQ-032 While reset is high, outputs are: init_cmd=0, init_mode=0, init_cmd_valid=0, cal_req=0, lpddr_calib_done=0, lpddr_calib_fail=0.
REQ-033 While reset is high, state is S_PWRUP and all counters and the attempt counter are 0.
REQ-034 Reset asserted mid-operation (including while a command is awaiting ack) clears everything immediately, without a clock edge.
REQ-035 After reset deasserts, the full sequence restarts from S_PWRUP.

Verification
(Scenarios 1-5 use PWRUP_CYCLES=4, TRP_CYCLES=2, TRFC_CYCLES=3, CAL_TIMEOUT=8, CAL_RETRIES=3.)
REQ-036 Nominal: ack same cycle as valid, cal_pass on the 2nd cycle after cal_req ->
- command order 1,2,2,3,4;
- init_mode=14'h0032 with cmd 3 and 14'h0000 with cmd 4;
- idle gaps 2,3,3,2,2 cycles;
- one cal_req; lpddr_calib_done high and stays high.
REQ-037 Slow PHY: ack 5 cycles after valid on PRECHARGE_ALL -> init_cmd and valid stable for all 5 cycles; valid low on the next cycle.
REQ-038 Retry: cal_pass=0, then cal_pass=1 -> two cal_req pulses; calib_done high; calib_fail low.
REQ-039 Timeout: no cal_done ever -> three cal_req pulses, each 8+ cycles apart; lpddr_calib_fail high; calib_done low.
REQ-040 Simultaneity: cal_done with cal_pass=1 on the timeout cycle -> S_DONE, not a retry.
REQ-041 Reset mid-REF2 with valid high -> all outputs 0 asynchronously; after release the sequence restarts, with PRECHARGE issued after 4 power-up cycles.
